enum_lane_pipe: RTL and testbench

// - NCH independent lanes, each a DEPTH-stage valid/ready register pipeline carrying pkg_v2::alias_t values.
// - Each input value is checked against the legal enum encodings (ONE=0, TWO=1, THREE=2).
// - Illegal values are flagged and forwarded, or dropped, depending on DROP_ILLEGAL.
// - Each lane counts its illegal values in a saturating counter.
// - Sits between typed-enum producers and consumers, replacing bare combinational alias passthroughs.

---
 rtl/enum_lane_pipe_pkg.sv | 26 ++
 rtl/enum_lane_pipe_lane.sv | 78 +++++++
 rtl/enum_lane_pipe.sv | 50 +++++
 tb/tb_enum_lane_pipe.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/enum_lane_pipe_pkg.sv
// pkg_v2: shared types for the typed-enum lane pipeline.
//   ENUM_W   - width of the enum encoding
//   enum_t   - legal encodings ONE=0, TWO=1, THREE=2 (other values arrive as raw bits)
//   alias_t  - alias of enum_t used on every lane port
//   stage_t  - one pipeline register: legality flag plus raw value
//   is_legal - true when the raw value is one of the enum encodings
package pkg_v2;

  localparam int ENUM_W = 8;

  typedef enum logic [ENUM_W-1:0] {ONE = 8'd0, TWO = 8'd1, THREE = 8'd2} enum_t;
  typedef enum_t alias_t;

  typedef struct packed {
    logic   illeg;
    alias_t val;
  } stage_t;

  // Compare on the raw bits so out-of-range values are judged correctly.
  function automatic logic is_legal(alias_t v);
    logic [ENUM_W-1:0] raw;
    raw = v;
    return raw < ENUM_W'(3);
  endfunction

endpackage

// File: rtl/enum_lane_pipe_lane.sv
// enum_lane: one lane of the enum pipeline.
//   DEPTH-stage valid/ready register chain, legality tagged at acceptance,
//   optional drop of illegal values, saturating illegal counter.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake, in_data raw alias_t bits
//   out_valid/out_ready   downstream handshake, out_data raw value, out_illeg flag
//   err_cnt, clr_err      illegal counter and its synchronous clear
module enum_lane
  import pkg_v2::*;
#(
  parameter int CNT_W        = 8,
  parameter int DEPTH        = 2,
  parameter bit DROP_ILLEGAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ENUM_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ENUM_W-1:0] out_data,
  output logic              out_illeg,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_err
);

  logic [DEPTH-1:0]        vld;
  stage_t [DEPTH-1:0]      st;
  logic [DEPTH:0]          rdy;
  logic                    acc, legal, keep;

  // Ready ripples back from the output: a stage can load if it is empty
  // or its successor is taking its contents this cycle.
  assign rdy[DEPTH] = out_ready;
  for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
    assign rdy[k] = !vld[k] | rdy[k+1];
  end

  assign in_ready = rdy[0];
  assign acc      = in_valid & rdy[0];
  assign legal    = is_legal(alias_t'(in_data));
  // In drop mode an illegal value is consumed but leaves a bubble.
  assign keep     = !DROP_ILLEGAL | legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (rdy[0]) vld[0] <= acc & keep;
      for (int k = 1; k < DEPTH; k++)
        if (rdy[k]) vld[k] <= vld[k-1];
    end
  end

  // Stage data needs no reset; it is qualified by vld everywhere.
  always_ff @(posedge clk) begin
    if (acc) begin
      st[0].illeg <= !legal;
      st[0].val   <= alias_t'(in_data);
    end
    for (int k = 1; k < DEPTH; k++)
      if (rdy[k]) st[k] <= st[k-1];
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            err_cnt <= '0;
    else if (clr_err)                      err_cnt <= '0;
    else if (acc && !legal && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = st[DEPTH-1].val;
  assign out_illeg = DROP_ILLEGAL ? 1'b0 : (vld[DEPTH-1] & st[DEPTH-1].illeg);

endmodule

// File: rtl/enum_lane_pipe.sv
// enum_lane_pipe: NCH independent enum_lane pipelines with packed lane ports.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    per-lane upstream handshake; in_data [NCH-1:0] raw alias_t
//   out_valid/out_ready  per-lane downstream handshake; out_data raw value
//   out_illeg            per-lane flag, high with out_valid for illegal values
//   err_cnt              per-lane saturating illegal counters
//   clr_err              clears every err_cnt
module enum_lane_pipe
  import pkg_v2::*;
#(
  parameter int NCH          = 2,
  parameter int DEPTH        = 2,
  parameter bit DROP_ILLEGAL = 1'b0,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             in_valid,
  output logic [NCH-1:0]             in_ready,
  input  logic [NCH-1:0][ENUM_W-1:0] in_data,
  output logic [NCH-1:0]             out_valid,
  input  logic [NCH-1:0]             out_ready,
  output logic [NCH-1:0][ENUM_W-1:0] out_data,
  output logic [NCH-1:0]             out_illeg,
  output logic [NCH-1:0][CNT_W-1:0]  err_cnt,
  input  logic                       clr_err
);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    enum_lane #(
      .CNT_W       (CNT_W),
      .DEPTH       (DEPTH),
      .DROP_ILLEGAL(DROP_ILLEGAL)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[i]),
      .in_ready (in_ready[i]),
      .in_data  (in_data[i]),
      .out_valid(out_valid[i]),
      .out_ready(out_ready[i]),
      .out_data (out_data[i]),
      .out_illeg(out_illeg[i]),
      .err_cnt  (err_cnt[i]),
      .clr_err  (clr_err)
    );
  end

endmodule

// File: tb/tb_enum_lane_pipe.sv
// Directed bench: forward-mode pipe with 2-bit counters and drop-mode pipe
// with 8-bit counters, both NCH=2, DEPTH=2, sharing clock, reset and clear.
module tb_enum_lane_pipe;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr_err = 1'b0;

  logic [1:0]      in_valid = '0, in_ready, out_valid, out_ready = '1, out_illeg;
  logic [1:0][7:0] in_data = '0, out_data;
  logic [1:0][1:0] err_cnt;

  logic [1:0]      d_in_valid = '0, d_in_ready, d_out_valid, d_out_ready = '1, d_out_illeg;
  logic [1:0][7:0] d_in_data = '0, d_out_data;
  logic [1:0][7:0] d_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enum_lane_pipe #(.NCH(2), .DEPTH(2), .DROP_ILLEGAL(1'b0), .CNT_W(2)) u_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_illeg(out_illeg),
    .err_cnt(err_cnt), .clr_err(clr_err)
  );

  enum_lane_pipe #(.NCH(2), .DEPTH(2), .DROP_ILLEGAL(1'b1), .CNT_W(8)) u_drop (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_illeg(d_out_illeg),
    .err_cnt(d_err_cnt), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held 3 cycles
    repeat (3) tick;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_d_out_valid", 32'(d_out_valid), 32'h0);
    chk("rst_d_err_cnt", 32'(d_err_cnt), 32'h0);
    rst_n = 1'b1;
    tick;
    chk("rel_in_ready", 32'(in_ready), 32'h3);

    // Stream TWO, THREE, ONE on lane0
    in_valid = 2'b01; in_data[0] = 8'd1;
    tick;
    chk("str_lat_empty", 32'(out_valid[0]), 32'h0);
    in_data[0] = 8'd2;
    tick;
    chk("str_v0", 32'(out_valid[0]), 32'h1);
    chk("str_d0", 32'(out_data[0]), 32'h1);
    chk("str_i0", 32'(out_illeg[0]), 32'h0);
    in_data[0] = 8'd0;
    tick;
    chk("str_d1", 32'(out_data[0]), 32'h2);
    in_valid = 2'b00;
    tick;
    chk("str_v2", 32'(out_valid[0]), 32'h1);
    chk("str_d2", 32'(out_data[0]), 32'h0);
    tick;
    chk("str_done", 32'(out_valid[0]), 32'h0);

    // Backpressure on lane0
    out_ready = 2'b10;
    in_valid = 2'b01; in_data[0] = 8'd0;
    chk("bp_rdy0", 32'(in_ready[0]), 32'h1);
    tick;
    in_data[0] = 8'd1;
    chk("bp_rdy1", 32'(in_ready[0]), 32'h1);
    tick;
    chk("bp_full", 32'(in_ready[0]), 32'h0);
    in_data[0] = 8'd2;
    tick;
    chk("bp_hold_rdy", 32'(in_ready[0]), 32'h0);
    chk("bp_hold_d", 32'(out_data[0]), 32'h0);
    tick;
    chk("bp_hold_v", 32'(out_valid[0]), 32'h1);
    in_valid = 2'b00; out_ready = 2'b11;
    chk("bp_drain0", 32'(out_data[0]), 32'h0);
    tick;
    chk("bp_drain1_v", 32'(out_valid[0]), 32'h1);
    chk("bp_drain1", 32'(out_data[0]), 32'h1);
    tick;
    chk("bp_empty", 32'(out_valid[0]), 32'h0);

    // Illegal 8'hFF in both modes
    in_valid = 2'b01; in_data[0] = 8'hFF;
    d_in_valid = 2'b01; d_in_data[0] = 8'hFF;
    tick;
    in_valid = 2'b00; d_in_valid = 2'b00;
    chk("ill_cnt_fwd", 32'(err_cnt[0]), 32'h1);
    chk("ill_cnt_drop", 32'(d_err_cnt[0]), 32'h1);
    tick;
    chk("ill_fwd_v", 32'(out_valid[0]), 32'h1);
    chk("ill_fwd_flag", 32'(out_illeg[0]), 32'h1);
    chk("ill_fwd_d", 32'(out_data[0]), 32'hFF);
    chk("ill_drop_none", 32'(d_out_valid), 32'h0);
    d_in_valid = 2'b01; d_in_data[0] = 8'd1;
    tick;
    d_in_valid = 2'b00;
    tick;
    chk("drop_legal_v", 32'(d_out_valid[0]), 32'h1);
    chk("drop_legal_d", 32'(d_out_data[0]), 32'h1);
    chk("drop_legal_i", 32'(d_out_illeg[0]), 32'h0);
    tick;

    // Clear, then both lanes count in the same cycle
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    chk("clr_fwd", 32'(err_cnt), 32'h0);
    chk("clr_drop", 32'(d_err_cnt), 32'h0);
    in_valid = 2'b11; in_data[0] = 8'hFF; in_data[1] = 8'h03;
    tick;
    in_valid = 2'b00;
    chk("par_cnt", 32'(err_cnt), 32'h5);

    // Saturation on lane0: 1 + 5 illegal -> 3
    in_valid = 2'b01; in_data[0] = 8'h80;
    repeat (2) tick;
    chk("sat_reach", 32'(err_cnt[0]), 32'h3);
    repeat (3) tick;
    chk("sat_hold", 32'(err_cnt[0]), 32'h3);
    chk("sat_other", 32'(err_cnt[1]), 32'h1);
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0; in_valid = 2'b00;
    chk("clr_wins", 32'(err_cnt), 32'h0);
    repeat (2) tick;

    // Lane1 stalled while lane0 streams
    out_ready = 2'b01;
    in_valid = 2'b10; in_data[1] = 8'd2;
    tick;
    in_data[1] = 8'd0;
    tick;
    in_data[1] = 8'd1;
    in_valid = 2'b11; in_data[0] = 8'd2;
    tick;
    in_data[0] = 8'd1;
    tick;
    chk("ln_l0_d", 32'(out_data[0]), 32'h2);
    chk("ln_l1_hold", 32'(out_data[1]), 32'h2);
    chk("ln_l1_rdy", 32'(in_ready[1]), 32'h0);
    in_data[0] = 8'd0;
    tick;
    chk("ln_l0_v", 32'(out_valid[0]), 32'h1);
    chk("ln_l0_d2", 32'(out_data[0]), 32'h1);

    // Mid-stream reset
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    tick;
    rst_n = 1'b1; in_valid = 2'b00; out_ready = 2'b11;
    tick;
    chk("post_rst_v0", 32'(out_valid), 32'h0);
    tick;
    chk("post_rst_v1", 32'(out_valid), 32'h0);
    chk("post_rst_rdy", 32'(in_ready), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
